// File: rtl/rotate_cmd_pipe.sv
// Command FIFO plus registered result stage around a combinational rotator.
// Define ROT_CMD_PIPE_STATS_EN to add the op_count completion counter.
module rotate_cmd_pipe #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_data,
  input  logic                     in_dir,
  input  logic [4:0]               in_shift,
  output logic [31:0]              rot_data_in,
  output logic                     rot_direction,
  output logic [4:0]               rot_shift,
  input  logic [31:0]              rot_data_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_data,
  output logic [$clog2(DEPTH):0]   level
`ifdef ROT_CMD_PIPE_STATS_EN
  ,
  output logic [15:0]              op_count
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  typedef struct packed {
    logic [31:0] data;
    logic        dir;
    logic [4:0]  shift;
  } cmd_t;

  typedef enum logic {S_EMPTY, S_LOADED} state_t;

  cmd_t          mem_q [DEPTH];
  cmd_t          mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   level_q, level_d;
  logic [31:0]   out_data_q, out_data_d;
  state_t        state_q, state_d;
  logic          push, pop, not_empty;

  assign not_empty = (level_q != '0);
  assign in_ready  = (level_q < FULL);
  assign push      = in_valid && in_ready;
  // The head leaves the FIFO exactly when the result register loads.
  assign pop       = not_empty && (state_q == S_EMPTY || out_ready);

  always_comb begin
    rot_data_in   = '0;
    rot_direction = 1'b0;
    rot_shift     = '0;
    if (not_empty) begin
      rot_data_in   = mem_q[rd_ptr_q].data;
      rot_direction = mem_q[rd_ptr_q].dir;
      rot_shift     = mem_q[rd_ptr_q].shift;
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{data: in_data, dir: in_dir, shift: in_shift};
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    out_data_d = out_data_q;
    if (pop) out_data_d = rot_data_out;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_EMPTY:  if (not_empty) state_d = S_LOADED;
      S_LOADED: if (out_ready) state_d = not_empty ? S_LOADED : S_EMPTY;
      default:  state_d = S_EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (state_q == S_LOADED);
    out_data  = out_data_q;
    level     = level_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      out_data_q <= '0;
      state_q    <= S_EMPTY;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      out_data_q <= out_data_d;
      state_q    <= state_d;
    end
  end

`ifdef ROT_CMD_PIPE_STATS_EN
  logic [15:0] op_count_q, op_count_d;

  always_comb begin
    op_count_d = op_count_q;
    if (out_valid && out_ready) op_count_d = op_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) op_count_q <= '0;
    else        op_count_q <= op_count_d;
  end

  assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_rotate_cmd_pipe.sv
// Scoreboard bench for rotate_cmd_pipe with a behavioural rotator attached.
// Expected results come from a bit-at-a-time rotate model.
module tb_rotate_cmd_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        in_dir = 1'b0;
  logic [4:0]  in_shift = '0;
  logic [31:0] rot_data_in;
  logic        rot_direction;
  logic [4:0]  rot_shift;
  logic [31:0] rot_data_out;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [2:0]  level;
`ifdef ROT_CMD_PIPE_STATS_EN
  logic [15:0] op_count;
  int          ops_model = 0;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];

  rotate_cmd_pipe #(.DEPTH(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_dir(in_dir),
    .in_shift(in_shift),
    .rot_data_in(rot_data_in),
    .rot_direction(rot_direction),
    .rot_shift(rot_shift),
    .rot_data_out(rot_data_out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .level(level)
`ifdef ROT_CMD_PIPE_STATS_EN
    ,
    .op_count(op_count)
`endif
  );

  always #5 clk = ~clk;

  // Stand-in for the external barrel rotator.
  logic [63:0] dbl;
  always_comb begin
    dbl = {rot_data_in, rot_data_in};
    if (rot_direction) dbl = dbl >> rot_shift;
    else               dbl = (dbl << rot_shift) >> 32;
    rot_data_out = dbl[31:0];
  end

  function automatic logic [31:0] rot_ref(logic [31:0] d, logic dir,
                                          logic [4:0] sh);
    logic [31:0] r = d;
    for (int i = 0; i < int'(sh); i++)
      r = dir ? {r[0], r[31:1]} : {r[30:0], r[31]};
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic v, logic [31:0] d, logic dir, logic [4:0] sh);
    in_valid = v;
    in_data  = d;
    in_dir   = dir;
    in_shift = sh;
    if (v && in_ready) sb.push_back(rot_ref(d, dir, sh));
  endtask

  task automatic drive_rand();
    drive(1'b1, $urandom, 1'($urandom), 5'($urandom));
  endtask

  task automatic drain(string name);
    for (int i = 0; i < 30; i++) begin
      if (sb.size() == 0 && !out_valid) break;
      cyc();
    end
    chk(name, 32'(sb.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", out_data, 32'hxxxx_xxxx);
      end else begin
        chk("result", out_data, sb.pop_front());
      end
`ifdef ROT_CMD_PIPE_STATS_EN
      ops_model++;
`endif
    end
  end

  logic [31:0] held;
  int          acc;

  initial begin
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_rot_data", rot_data_in, 32'd0);
    chk("rst_rot_ctl", 32'({rot_direction, rot_shift}), 32'd0);
    cyc();
    rst_n = 1'b1;

    // Single rotate right, latency two edges.
    cyc();
    drive(1'b1, 32'h8000_0001, 1'b1, 5'd1);
    cyc();
    drive(1'b0, '0, 1'b0, '0);
    chk("lat_valid_early", 32'(out_valid), 32'd0);
    chk("lat_level", 32'(level), 32'd1);
    chk("lat_rot_data", rot_data_in, 32'h8000_0001);
    cyc();
    chk("lat_valid", 32'(out_valid), 32'd1);
    chk("lat_data", out_data, 32'hC000_0000);
    chk("lat_level0", 32'(level), 32'd0);
    out_ready = 1'b1;
    drain("drain_single");

    // Left rotate and shift 0 back-to-back.
    cyc();
    drive(1'b1, 32'h1234_5678, 1'b0, 5'd4);
    cyc();
    drive(1'b1, 32'hDEAD_BEEF, 1'b1, 5'd0);
    cyc();
    drive(1'b0, '0, 1'b0, '0);
    chk("left_data", out_data, 32'h2345_6781);
    cyc();
    chk("shift0_valid", 32'(out_valid), 32'd1);
    chk("shift0_data", out_data, 32'hDEAD_BEEF);
    drain("drain_pair");

    // Back-pressure: six pushes, five accepted.
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (in_ready) acc++;
      drive_rand();
      if (i == 2) held = out_data;
    end
    cyc();
    drive(1'b0, '0, 1'b0, '0);
    chk("bp_accepted", 32'(acc), 32'd5);
    chk("bp_level", 32'(level), 32'd4);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_head_result", out_data, sb[0]);
    chk("bp_stable", out_data, held);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (i < 4) chk("bp_stream_valid", 32'(out_valid), 32'd1);
    end
    drain("drain_bp");

    // Streaming with pointer wrap, no bubbles after the first.
    for (int i = 0; i < 20; i++) begin
      cyc();
      drive_rand();
      if (i >= 2) chk("stream_valid", 32'(out_valid), 32'd1);
      chk("stream_in_ready", 32'(in_ready), 32'd1);
    end
    cyc();
    drive(1'b0, '0, 1'b0, '0);
    drain("drain_stream");

    // Random valid/ready traffic.
    for (int i = 0; i < 300; i++) begin
      cyc();
      out_ready = 1'($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) != 0) drive_rand();
      else drive(1'b0, '0, 1'b0, '0);
    end
    cyc();
    drive(1'b0, '0, 1'b0, '0);
    out_ready = 1'b1;
    drain("drain_random");

    // Reset with three queued and one held result.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      drive_rand();
    end
    cyc();
    drive(1'b0, '0, 1'b0, '0);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    chk("pre_rst_level", 32'(level), 32'd3);
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_data", out_data, 32'd0);
    cyc();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("post_rst_idle", 32'(out_valid), 32'd0);
    end
`ifdef ROT_CMD_PIPE_STATS_EN
    ops_model = 0;
`endif
    cyc();
    drive(1'b1, 32'h0000_00F0, 1'b0, 5'd31);
    cyc();
    drive(1'b0, '0, 1'b0, '0);
    drain("drain_post_rst");

`ifdef ROT_CMD_PIPE_STATS_EN
    for (int i = 0; i < 10; i++) begin
      cyc();
      drive_rand();
    end
    cyc();
    drive(1'b0, '0, 1'b0, '0);
    drain("drain_stats");
    chk("op_count", 32'(op_count), 32'(ops_model % 65536));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
